lfsr_axil_slave: RTL

LFSR_AXIL_SLAVE -- requirements
Module: lfsr_axil_slave

---
 rtl/lfsr_axil_slave.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lfsr_axil_slave.sv
// LFSR stream generator with an AXI-Lite control slave.
// Registers: start (0x0), stop (0x4), seed (0x8), taps (0xC).
module lfsr_axil_slave #(
    parameter int LFSR_W = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  lfsr_s_axi_awaddr,
    input  logic        lfsr_s_axi_awvalid,
    output logic        lfsr_s_axi_awready,
    input  logic [31:0] lfsr_s_axi_wdata,
    input  logic        lfsr_s_axi_wvalid,
    output logic        lfsr_s_axi_wready,
    output logic [1:0]  lfsr_s_axi_bresp,
    output logic        lfsr_s_axi_bvalid,
    input  logic        lfsr_s_axi_bready,
    input  logic [3:0]  lfsr_s_axi_araddr,
    input  logic        lfsr_s_axi_arvalid,
    output logic        lfsr_s_axi_arready,
    output logic [31:0] lfsr_s_axi_rdata,
    output logic [1:0]  lfsr_s_axi_rresp,
    output logic        lfsr_s_axi_rvalid,
    input  logic        lfsr_s_axi_rready,
    output logic [31:0] lfsr_m_axis_tdata,
    output logic        lfsr_m_axis_tvalid,
    input  logic        lfsr_m_axis_tready
);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t          w_state;
    r_state_t          r_state;
    logic              start_reg;
    logic              stop_reg;
    logic [LFSR_W-1:0] seed_reg;
    logic [LFSR_W-1:0] taps_reg;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] ld_val;
    logic              running;
    logic              wr_hs;
    logic              rd_hs;
    logic              step;
    logic              fb;
    logic              start_ld;
    logic [31:0]       lfsr_ext;
    logic [31:0]       seed_ext;
    logic [31:0]       taps_ext;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign unused_bits = ^{lfsr_s_axi_awaddr[1:0],
                           lfsr_s_axi_araddr[1:0],
                           lfsr_s_axi_wdata};

    assign wr_hs = (w_state == W_IDLE) &&
                   lfsr_s_axi_awvalid && lfsr_s_axi_wvalid;
    assign lfsr_s_axi_awready = wr_hs;
    assign lfsr_s_axi_wready  = wr_hs;
    assign lfsr_s_axi_bvalid  = (w_state == W_RESP);
    assign lfsr_s_axi_bresp   = 2'b00;

    assign lfsr_s_axi_arready = (r_state == R_IDLE);
    assign rd_hs              = lfsr_s_axi_arvalid && lfsr_s_axi_arready;
    assign lfsr_s_axi_rvalid  = (r_state == R_DATA);
    assign lfsr_s_axi_rresp   = 2'b00;

    assign running            = start_reg && !stop_reg;
    assign lfsr_m_axis_tvalid = running;
    assign lfsr_m_axis_tdata  = lfsr_ext;
    assign step               = running && lfsr_m_axis_tready;
    assign fb                 = ^(lfsr & taps_reg);
    assign start_ld = wr_hs && (lfsr_s_axi_awaddr[3:2] == 2'd0) &&
                      lfsr_s_axi_wdata[0];
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign ld_val = (seed_reg == '0) ?
                    {{(LFSR_W-1){1'b0}}, 1'b1} : seed_reg;

    always_comb begin
        lfsr_ext = '0;
        seed_ext = '0;
        taps_ext = '0;
        lfsr_ext[LFSR_W-1:0] = lfsr;
        seed_ext[LFSR_W-1:0] = seed_reg;
        taps_ext[LFSR_W-1:0] = taps_reg;
    end

    always_comb begin
        rd_mux = '0;
        case (lfsr_s_axi_araddr[3:2])
            2'd0:    rd_mux = {30'd0, running, start_reg};
            2'd1:    rd_mux = {31'd0, stop_reg};
            2'd2:    rd_mux = seed_ext;
            default: rd_mux = taps_ext;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            start_reg <= 1'b0;
            stop_reg  <= 1'b0;
            seed_reg  <= '0;
            taps_reg  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_hs) begin
                        case (lfsr_s_axi_awaddr[3:2])
                            2'd0:    start_reg <= lfsr_s_axi_wdata[0];
                            2'd1:    stop_reg  <= lfsr_s_axi_wdata[0];
                            2'd2:    seed_reg  <= lfsr_s_axi_wdata[LFSR_W-1:0];
                            default: taps_reg  <= lfsr_s_axi_wdata[LFSR_W-1:0];
                        endcase
                        w_state <= W_RESP;
                    end
                end
                default: begin
                    if (lfsr_s_axi_bready)
                        w_state <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state          <= R_IDLE;
            lfsr_s_axi_rdata <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_hs) begin
                        lfsr_s_axi_rdata <= rd_mux;
                        r_state          <= R_DATA;
                    end
                end
                default: begin
                    if (lfsr_s_axi_rready)
                        r_state <= R_IDLE;
                end
            endcase
        end
    end

    // A start write wins over a step on the same edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            lfsr <= '0;
        else if (start_ld)
            lfsr <= ld_val;
        else if (step)
            lfsr <= {lfsr[LFSR_W-2:0], fb};
    end

endmodule
